data_ram_resp: RTL and testbench
================================

Name: data_ram_resp

Overview:
- Responder at the far end of the MEM-stage data-memory port: accepts ce/we/addr/sel/data from the MEM stage and returns read data combinationally in the same cycle.
- Backs a word-organised RAM with big-endian byte lanes: sel[3] and data[31:24] are the lowest byte address.
- Writes are posted through a one-entry write buffer. Reads forward buffered bytes per lane.
- Flags illegal byte-enable patterns.

Parameters:
- ADDR_W, 10, word-address width; the RAM holds 2**ADDR_W 32-bit words.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ce_i  in  1  access valid this cycle.
- we_i  in  1  1 = store, 0 = load; meaningful only when ce_i=1.
- addr_i  in  32  byte address; word index = addr_i[ADDR_W+1:2]; higher bits ignored (RAM aliases).
- sel_i  in  4  byte-lane enables; sel_i[3] maps to data[31:24].
- data_i  in  32  store data, already lane-replicated by MEM.
- data_o  out  32  load data, combinational.
- err_o  out  1  combinational illegal-access flag.
- err_sticky_o  out  1  registered; set by any illegal access, cleared only by rst.

Behaviour:
- Legal sel_i values: 0001, 0010, 0100, 1000, 0011, 1100, 0111, 1110, 1111.
- err_o = ce_i & ~rst & (sel_i not legal). This includes 0000, which MEM drives for a misaligned SH/SB.
- Accepted write: ce_i=1, we_i=1, err_o=0, rst=0. A write with err_o=1 is dropped: no buffer or array change.
- Write buffer state: wb_v, wb_idx[ADDR_W-1:0], wb_sel[3:0], wb_dat[31:0].
- Each rising edge with rst=0:
  - If wb_v=1, commit lanes wb_sel of wb_dat into array[wb_idx].
  - If an accepted write is present, load the buffer with the new access and set wb_v=1; otherwise clear wb_v.
  - Commit happens before capture on the same edge, so back-to-back writes to the same word merge correctly.
- Store-to-array latency: 2 edges. Store visibility to loads: the next cycle, via forwarding.
- Load: ce_i=1, we_i=0, rst=0.
  - data_o always returns the full 32-bit word regardless of sel_i; MEM extracts lanes.
  - If wb_v=1 and wb_idx matches the load's word index, lane n comes from wb_dat when wb_sel[n]=1, otherwise from the array.
  - Otherwise data_o = array[index].
- data_o = 0 when rst=1, ce_i=0, or we_i=1.
- A load of an illegal sel still returns data and raises err_o; err_sticky_o sets on the edge.
- Reset, applied on any edge with rst=1:
  - wb_v <= 0; a pending buffered write is discarded and never reaches the array.
  - err_sticky_o <= 0.
  - Array contents are not reset.
  - Bus accesses during rst are ignored.
- Combinational outputs during rst: data_o=0, err_o=0.
- Index wrap: addr_i bits above ADDR_W+1 are ignored; addr 0x0000_1000 aliases word 0 when ADDR_W=10.
- Address bits [1:0] are ignored; lane selection comes only from sel_i.

Optional Feature:
- Macro: DATA_RAM_STATS_EN.
- Defined:
  - Adds 32-bit wrapping counters rd_cnt (incremented per load with ce_i=1) and wr_cnt (incremented per accepted write). Both reset to 0.
  - Loads from addr_i=0xFFFF_FFF0 return rd_cnt; loads from 0xFFFF_FFF4 return wr_cnt. Counter values are the pre-increment values, and the counter load itself still counts.
  - Writes to either address are not buffered, do not touch the array, and do not count.
- Undefined: no counters; those addresses alias RAM words like any other address.

Test Plan:
- Store word then load:
  - Stimulus: write idx 5, sel 1111, data 0x11223344; next cycle load idx 5.
  - Required: data_o=0x11223344 via forwarding; the load two cycles later reads the same value from the array.
- Byte merge:
  - Stimulus: word 7 preloaded 0xAABBCCDD; back-to-back writes sel 1000 data 0x55555555, then sel 0001 data 0x66666666; then load word 7.
  - Required: data_o=0x55BBCC66.
- Illegal sel:
  - Stimulus: write word 3 with sel 0000, then sel 1010.
  - Required: err_o=1 in both cycles; err_sticky_o=1 after the first edge; word 3 unchanged; after rst, err_sticky_o=0.
- Reset mid-operation:
  - Stimulus: word 9 holds 0x0; write 0xDEADBEEF sel 1111 to word 9 with rst=1 on the following edge; deassert rst; load word 9.
  - Required: data_o=0x00000000 (buffered write discarded).
- Alias and idle:
  - Stimulus: ADDR_W=10; write 0x12345678 to addr 0x0000_1008; load addr 0x0000_0008.
  - Required: data_o=0x12345678. With ce_i=0, data_o=0.
- Stats (DATA_RAM_STATS_EN):
  - Stimulus: after rst, 3 accepted writes, then 2 loads, then load 0xFFFF_FFF0 and 0xFFFF_FFF4.
  - Required: 0xFFFF_FFF0 returns 2; 0xFFFF_FFF4 returns 3.

Source files
------------

// File: rtl/data_ram_resp_if.sv
// ---------------------------------------------------------------------------
// data_ram_resp_if
//
// Purpose:
//   Bundles the MEM-stage data-memory port between the pipeline (master)
//   and the data RAM responder (slave). Signal names keep the _i/_o
//   suffixes as seen from the responder, so they line up with the
//   responder's datasheet view.
//
// Signals:
//   ce_i         access valid this cycle
//   we_i         1 = store, 0 = load
//   addr_i[31:0] byte address (word index taken from the upper bits)
//   sel_i[3:0]   big-endian byte-lane enables, sel_i[3] -> data[31:24]
//   data_i[31:0] store data, already lane-replicated by MEM
//   data_o[31:0] load data, combinational
//   err_o        combinational illegal-access flag
//   err_sticky_o registered illegal-access flag, cleared only by reset
//
// Modports:
//   master : MEM stage side (drives the request, receives the response)
//   slave  : RAM responder side
// ---------------------------------------------------------------------------
interface data_ram_resp_if;

    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        err_o;
    logic        err_sticky_o;

    // The pipeline side issues requests and observes the response.
    modport master (
        output ce_i,
        output we_i,
        output addr_i,
        output sel_i,
        output data_i,
        input  data_o,
        input  err_o,
        input  err_sticky_o
    );

    // The RAM side consumes requests and produces the response.
    modport slave (
        input  ce_i,
        input  we_i,
        input  addr_i,
        input  sel_i,
        input  data_i,
        output data_o,
        output err_o,
        output err_sticky_o
    );

endinterface

// File: rtl/data_ram_resp.sv
// ---------------------------------------------------------------------------
// data_ram_resp
//
// Purpose:
//   Responder at the far end of the MEM-stage data-memory port. Backs a
//   word-organised RAM with big-endian byte lanes (sel[3] / data[31:24] is
//   the lowest byte address). Loads return the full 32-bit word in the same
//   cycle. Stores are posted through a one-entry write buffer and committed
//   to the array on the following edge; loads forward buffered lanes so a
//   store is visible to the very next load. Illegal byte-enable patterns
//   raise a combinational error flag and a sticky registered flag.
//
// Parameters:
//   ADDR_W  word-address width; the array holds 2**ADDR_W 32-bit words.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (clears buffer and sticky error,
//         leaves array contents alone)
//   bus   data_ram_resp_if.slave (ce_i, we_i, addr_i, sel_i, data_i in;
//         data_o, err_o, err_sticky_o out)
//
// Optional build feature (macro DATA_RAM_STATS_EN):
//   Adds wrapping 32-bit load/store counters. Loads from 0xFFFF_FFF0 return
//   the load count and loads from 0xFFFF_FFF4 return the accepted-store
//   count (values before this cycle's increment). Stores to those two
//   addresses are swallowed. Without the macro those addresses are plain
//   aliases of RAM words.
// ---------------------------------------------------------------------------
module data_ram_resp #(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_resp_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    // Storage array. Deliberately not reset: software must not rely on
    // power-up contents, and keeping it reset-free lets it map onto RAM.
    logic [31:0] mem [0:DEPTH-1];

    // One-entry posted write buffer.
    logic              wb_v;
    logic [ADDR_W-1:0] wb_idx;
    logic [3:0]        wb_sel;
    logic [31:0]       wb_dat;

    // Sticky error flag.
    logic err_sticky;

    // Decoded request.
    logic [ADDR_W-1:0] idx;
    logic              sel_legal;
    logic              err;
    logic              load;
    logic              wr_accept;

    // Read path.
    logic [31:0] ram_word;
    logic        fwd_hit;
    logic [31:0] merged_word;
    logic [31:0] rdata;

    // Address bits outside the word index only alias, so they are
    // intentionally left unused in the default build.
    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};

    assign idx = bus.addr_i[ADDR_W+1:2];

    // Only contiguous lane groups that a byte, halfword (either half),
    // three-byte or full-word access can produce are legal. Everything
    // else, including 0000 (what MEM drives for a misaligned SH/SB), is
    // flagged.
    always_comb begin
        sel_legal = 1'b0;
        case (bus.sel_i)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100,
            4'b0111, 4'b1110,
            4'b1111: sel_legal = 1'b1;
            default: sel_legal = 1'b0;
        endcase
    end

    // The error flag is masked during reset so a bus that is still toggling
    // while the core is held in reset never reports a fault.
    assign err  = bus.ce_i & ~rst & ~sel_legal;
    assign load = bus.ce_i & ~bus.we_i & ~rst;

`ifdef DATA_RAM_STATS_EN
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;
    logic        is_rd_cnt_addr;
    logic        is_wr_cnt_addr;
    logic        stat_hit;

    assign is_rd_cnt_addr = (bus.addr_i == 32'hFFFF_FFF0);
    assign is_wr_cnt_addr = (bus.addr_i == 32'hFFFF_FFF4);
    assign stat_hit       = is_rd_cnt_addr | is_wr_cnt_addr;

    // Stores to the counter addresses are swallowed entirely.
    assign wr_accept = bus.ce_i & bus.we_i & ~rst & ~err & ~stat_hit;
`else
    assign wr_accept = bus.ce_i & bus.we_i & ~rst & ~err;
`endif

    assign ram_word = mem[idx];
    assign fwd_hit  = wb_v & (wb_idx == idx);

    // Lane-wise forwarding: a lane still sitting in the write buffer wins
    // over the (stale) array lane. Lanes the buffer does not cover come
    // from the array, which already holds any older commits.
    always_comb begin
        merged_word = ram_word;
        for (int n = 0; n < 4; n++) begin
            if (fwd_hit && wb_sel[n]) begin
                merged_word[n*8 +: 8] = wb_dat[n*8 +: 8];
            end
        end
    end

    // Load data is zero unless a load is actually in flight. The full word
    // is returned regardless of sel_i; MEM extracts and extends the lanes.
    always_comb begin
        rdata = 32'h0;
        if (load) begin
            rdata = merged_word;
`ifdef DATA_RAM_STATS_EN
            if (is_rd_cnt_addr) begin
                rdata = rd_cnt;
            end else if (is_wr_cnt_addr) begin
                rdata = wr_cnt;
            end
`endif
        end
    end

    assign bus.data_o       = rdata;
    assign bus.err_o        = err;
    assign bus.err_sticky_o = err_sticky;

    // Commit the buffered store into the array. This uses the buffer
    // contents from before this edge, so a store arriving on the same edge
    // is captured afterwards and back-to-back stores to one word merge in
    // order. A pending store is thrown away by reset.
    always_ff @(posedge clk) begin
        if (!rst && wb_v) begin
            for (int n = 0; n < 4; n++) begin
                if (wb_sel[n]) begin
                    mem[wb_idx][n*8 +: 8] <= wb_dat[n*8 +: 8];
                end
            end
        end
    end

    // Buffer valid bit: set by every accepted store, otherwise drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v <= 1'b0;
        end else begin
            wb_v <= wr_accept;
        end
    end

    // Buffer payload only changes on an accepted store; it is qualified by
    // wb_v so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            wb_idx <= idx;
            wb_sel <= bus.sel_i;
            wb_dat <= bus.data_i;
        end
    end

    // Sticky error accumulates every illegal access until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
        end else if (err) begin
            err_sticky <= 1'b1;
        end
    end

`ifdef DATA_RAM_STATS_EN
    // Statistics counters. Every load counts, including loads of the
    // counter addresses themselves; only accepted stores count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt <= 32'h0;
            wr_cnt <= 32'h0;
        end else begin
            if (load) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_accept) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_ram_resp.sv
// ---------------------------------------------------------------------------
// tb_data_ram_resp
//
// Purpose:
//   Directed, self-checking bench for data_ram_resp. Each scenario task
//   drives the bus and compares the responder outputs against values
//   worked out by hand. Inputs change 1 time unit after a rising edge and
//   outputs are sampled 1 time unit later, away from the edge.
//
// Ports: none (top-level bench). Instantiates data_ram_resp_if and
// data_ram_resp with ADDR_W = 10. The stats scenario is only built when
// DATA_RAM_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_data_ram_resp;

    logic clk;
    logic rst;

    int compared;
    int mismatched;

    data_ram_resp_if bus ();

    data_ram_resp #(
        .ADDR_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one bus request and let the combinational outputs settle.
    task automatic applyStimulus(input logic ce, input logic we,
                                 input logic [31:0] addr,
                                 input logic [3:0] sel,
                                 input logic [31:0] data);
        bus.ce_i   = ce;
        bus.we_i   = we;
        bus.addr_i = addr;
        bus.sel_i  = sel;
        bus.data_i = data;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset values, and output masking while reset is held with a request
    // (illegal sel) on the bus.
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        step();
        step();
        applyStimulus(1'b1, 1'b0, 32'h0, 4'b0000, 32'h0);
        compared++;
        if (bus.err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_err: err_o=%b expected 0", bus.err_o);
        end
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: data_o=%h expected 00000000", bus.data_o);
        end
        compared++;
        if (bus.err_sticky_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_sticky: err_sticky_o=%b expected 0", bus.err_sticky_o);
        end
        step();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
    endtask

    // Full-word store to word 5, forwarded load, then array load.
    task automatic test_store_load();
        applyStimulus(1'b1, 1'b1, 32'h0000_0014, 4'b1111, 32'h1122_3344);
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL store_data_zero: data_o=%h expected 00000000", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0014, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h1122_3344) begin
            mismatched++;
            $display("[TB] FAIL store_fwd: data_o=%h expected 11223344", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0014, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h1122_3344) begin
            mismatched++;
            $display("[TB] FAIL store_array: data_o=%h expected 11223344", bus.data_o);
        end
        step();
    endtask

    // Preload word 7, then two back-to-back single-byte stores.
    task automatic test_byte_merge();
        applyStimulus(1'b1, 1'b1, 32'h0000_001C, 4'b1111, 32'hAABB_CCDD);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_001C, 4'b1000, 32'h5555_5555);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_001C, 4'b0001, 32'h6666_6666);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_001C, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h55BB_CC66) begin
            mismatched++;
            $display("[TB] FAIL merge_fwd: data_o=%h expected 55bbcc66", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_001C, 4'b0010, 32'h0);
        compared++;
        if (bus.data_o !== 32'h55BB_CC66) begin
            mismatched++;
            $display("[TB] FAIL merge_array: data_o=%h expected 55bbcc66", bus.data_o);
        end
        step();
    endtask

    // Illegal sel stores to word 3 are flagged and dropped.
    task automatic test_illegal_sel();
        applyStimulus(1'b1, 1'b1, 32'h0000_000C, 4'b1111, 32'h3333_3333);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_000C, 4'b0000, 32'hFFFF_FFFF);
        compared++;
        if (bus.err_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL illegal_err0000: err_o=%b expected 1", bus.err_o);
        end
        compared++;
        if (bus.err_sticky_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_sticky_pre: err_sticky_o=%b expected 0", bus.err_sticky_o);
        end
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_000C, 4'b1010, 32'hFFFF_FFFF);
        compared++;
        if (bus.err_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL illegal_err1010: err_o=%b expected 1", bus.err_o);
        end
        compared++;
        if (bus.err_sticky_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL illegal_sticky_set: err_sticky_o=%b expected 1", bus.err_sticky_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_000C, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h3333_3333) begin
            mismatched++;
            $display("[TB] FAIL illegal_unchanged: data_o=%h expected 33333333", bus.data_o);
        end
        compared++;
        if (bus.err_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_legal_load: err_o=%b expected 0", bus.err_o);
        end
        step();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        step();
        rst = 1'b0;
        #1;
        compared++;
        if (bus.err_sticky_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL illegal_sticky_clear: err_sticky_o=%b expected 0", bus.err_sticky_o);
        end
    endtask

    // A buffered store to word 9 is discarded by reset on the next edge.
    task automatic test_reset_mid_op();
        applyStimulus(1'b1, 1'b1, 32'h0000_0024, 4'b1111, 32'h0000_0000);
        step();
        applyStimulus(1'b1, 1'b1, 32'h0000_0024, 4'b1111, 32'hDEAD_BEEF);
        step();
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_data_in_rst: data_o=%h expected 00000000", bus.data_o);
        end
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_discard: data_o=%h expected 00000000", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0024, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_array: data_o=%h expected 00000000", bus.data_o);
        end
        step();
    endtask

    // Upper address bits alias; idle bus returns zero.
    task automatic test_alias_idle();
        applyStimulus(1'b1, 1'b1, 32'h0000_1008, 4'b1111, 32'h1234_5678);
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_0008, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL alias_fwd: data_o=%h expected 12345678", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'h0000_000B, 4'b0001, 32'h0);
        compared++;
        if (bus.data_o !== 32'h1234_5678) begin
            mismatched++;
            $display("[TB] FAIL alias_array: data_o=%h expected 12345678", bus.data_o);
        end
        step();
        applyStimulus(1'b0, 1'b0, 32'h0000_0008, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL idle_data: data_o=%h expected 00000000", bus.data_o);
        end
        step();
    endtask

`ifdef DATA_RAM_STATS_EN
    // Counter readback after 3 stores and 2 loads.
    task automatic test_stats();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 32'h0000_0050 + 32'(i * 4), 4'b1111, 32'h0000_0100 + 32'(i));
            step();
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0000_0050 + 32'(i * 4), 4'b1111, 32'h0);
            step();
        end
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF0, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'd2) begin
            mismatched++;
            $display("[TB] FAIL stats_rd_cnt: data_o=%h expected 00000002", bus.data_o);
        end
        step();
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFF4, 4'b1111, 32'h0);
        compared++;
        if (bus.data_o !== 32'd3) begin
            mismatched++;
            $display("[TB] FAIL stats_wr_cnt: data_o=%h expected 00000003", bus.data_o);
        end
        step();
    endtask
`endif

    // Run every scenario in order, then report.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.ce_i   = 1'b0;
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h0;
        bus.sel_i  = 4'b0000;
        bus.data_i = 32'h0;

        $display("[TB] starting data_ram_resp directed tests");
        test_reset();
        test_store_load();
        test_byte_merge();
        test_illegal_sel();
        test_reset_mid_op();
        test_alias_idle();
`ifdef DATA_RAM_STATS_EN
        test_stats();
`endif
        applyStimulus(1'b0, 1'b0, 32'h0, 4'b0000, 32'h0);
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
